// File: rtl/hilo_ctrl.sv
// hilo_ctrl: architectural HI/LO registers and mul/div unit sequencer.
// Issues operands to an external unit and captures its results.
module hilo_ctrl #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        unit_start,
  output logic        unit_sel,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, start_n, sel_n;
  logic          dz_n, to_n;
  logic [31:0]   a_n, b_n, hi_n, lo_n;
  logic          rt_zero;

  assign rt_zero = (rt_val == 32'd0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    start_n = 1'b0;
    sel_n   = unit_sel;
    a_n     = unit_a;
    b_n     = unit_b;
    hi_n    = hi;
    lo_n    = lo;
    dz_n    = 1'b0;
    to_n    = timeout;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          op_valid && op == OP_MULT,
          op_valid && op == OP_DIV && !rt_zero: begin
            state_n = START;
            busy_n  = 1'b1;
            start_n = 1'b1;
            sel_n   = (op == OP_DIV);
            a_n     = rs_val;
            b_n     = rt_val;
          end
          op_valid && op == OP_DIV && rt_zero: dz_n = 1'b1;
          op_valid && op == OP_MTHI: hi_n = rs_val;
          op_valid && op == OP_MTLO: lo_n = rs_val;
          default: ;
        endcase
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        // a result on the final count still wins over the abort
        if (unit_done) begin
          hi_n    = unit_hi;
          lo_n    = unit_lo;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cnt == TMAX) begin
          to_n    = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      unit_start <= 1'b0;
      unit_sel   <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      hi         <= '0;
      lo         <= '0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      unit_start <= start_n;
      unit_sel   <= sel_n;
      unit_a     <= a_n;
      unit_b     <= b_n;
      hi         <= hi_n;
      lo         <= lo_n;
      div_zero   <= dz_n;
      timeout    <= to_n;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: random and directed checks of hilo_ctrl
// against a transaction-level model with a fake mul/div unit.
module tb_hilo_ctrl;

  localparam int T = 63;
  localparam logic [2:0] MULT = 3'b001;
  localparam logic [2:0] DIV  = 3'b010;
  localparam logic [2:0] MTHI = 3'b011;
  localparam logic [2:0] MTLO = 3'b100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, unit_start, unit_sel;
  logic [31:0] unit_a, unit_b, hi, lo;
  logic        unit_done = 1'b0;
  logic [31:0] unit_hi = '0;
  logic [31:0] unit_lo = '0;
  logic        div_zero, timeout;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_to = 1'b0;

  always #5 clock = ~clock;

  hilo_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clock(clock),
    .reset(reset),
    .op_valid(op_valid),
    .op(op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .busy(busy),
    .unit_start(unit_start),
    .unit_sel(unit_sel),
    .unit_a(unit_a),
    .unit_b(unit_b),
    .unit_done(unit_done),
    .unit_hi(unit_hi),
    .unit_lo(unit_lo),
    .hi(hi),
    .lo(lo),
    .div_zero(div_zero),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(unit_start), 32'd0);
    chk({tag, "_sel"}, 32'(unit_sel), 32'd0);
    chk({tag, "_a"}, unit_a, 32'd0);
    chk({tag, "_b"}, unit_b, 32'd0);
    chk({tag, "_hi"}, hi, 32'd0);
    chk({tag, "_lo"}, lo, 32'd0);
    chk({tag, "_dz"}, 32'(div_zero), 32'd0);
    chk({tag, "_to"}, 32'(timeout), 32'd0);
  endtask

  // Behaviour of an ideal unit: signed product or quotient/remainder.
  task automatic unit_result(input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] rh,
                             output logic [31:0] rl);
    longint pa, pb, p, q, r;
    logic [63:0] v, qv, rv;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    if (o == MULT) begin
      p = pa * pb;
      v = p;
      rh = v[63:32];
      rl = v[31:0];
    end else begin
      q = pa / pb;
      r = pa % pb;
      qv = q;
      rv = r;
      rh = rv[31:0];
      rl = qv[31:0];
    end
  endtask

  // Single-cycle ops: MTHI, MTLO, DIV by zero, NOPs. Called at a negedge.
  task automatic run_simple(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
    logic dz;
    op_valid = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    unit_done = 1'($urandom_range(0, 1));
    unit_hi = $urandom;
    unit_lo = $urandom;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    unit_done = 1'b0;
    dz = (o == DIV) && (b == 32'd0);
    if (o == MTHI) m_hi = a;
    if (o == MTLO) m_lo = a;
    @(negedge clock);
    chk("s_dz", 32'(div_zero), 32'(dz));
    chk("s_busy", 32'(busy), 32'd0);
    chk("s_start", 32'(unit_start), 32'd0);
    chk("s_hi", hi, m_hi);
    chk("s_lo", lo, m_lo);
    chk("s_to", 32'(timeout), 32'(m_to));
    if (dz) begin
      @(negedge clock);
      chk("s_dz_end", 32'(div_zero), 32'd0);
    end
  endtask

  // MULT/DIV: unit answers k WAIT cycles after entering WAIT.
  // With hold set, a DIV(ha,hb) request is kept on the bus while busy.
  task automatic run_arith(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int k,
                           input bit hold, input logic [31:0] ha,
                           input logic [31:0] hb, input bit spur);
    logic [31:0] rh, rl;
    int bc, ns, exp_bc;
    bit fin;
    unit_result(o, a, b, rh, rl);
    op_valid = 1'b1;
    op = o;
    rs_val = a;
    rt_val = b;
    unit_done = 1'b0;
    @(posedge clock);
    #1;
    if (hold) begin
      op = DIV;
      rs_val = ha;
      rt_val = hb;
    end else begin
      op_valid = 1'b0;
      rs_val = $urandom;
      rt_val = $urandom;
    end
    bc = 0;
    ns = 0;
    fin = 0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      @(negedge clock);
      if (!busy) begin
        fin = 1;
      end else begin
        bc++;
        if (unit_start) ns++;
        chk("a_start_cyc", 32'(unit_start), 32'(cyc == 1));
        chk("a_sel", 32'(unit_sel), 32'(o == DIV));
        chk("a_unit_a", unit_a, a);
        chk("a_unit_b", unit_b, b);
        unit_done = (cyc == k + 2) || (spur && cyc == 1);
        unit_hi = (cyc == k + 2) ? rh : $urandom;
        unit_lo = (cyc == k + 2) ? rl : $urandom;
      end
    end
    unit_done = 1'b0;
    if (k <= T) begin
      m_hi = rh;
      m_lo = rl;
      exp_bc = k + 2;
    end else begin
      m_to = 1'b1;
      exp_bc = T + 2;
    end
    chk("a_finished", 32'(fin), 32'd1);
    chk("a_busy_cycles", bc, exp_bc);
    chk("a_starts", ns, 32'd1);
    chk("a_hi", hi, m_hi);
    chk("a_lo", lo, m_lo);
    chk("a_to", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          k, r;

    #3 reset = 1'b0;
    #1 chk_zero("rst");
    @(negedge clock);
    reset = 1'b1;

    run_arith(MULT, 32'hFFFFFFFE, 32'd3, 1, 0, '0, '0, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    run_simple(DIV, 32'd7, 32'd0);

    run_simple(MTHI, 32'h12345678, 32'd0);
    run_simple(MTLO, 32'h9ABCDEF0, 32'd0);
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'h9ABCDEF0);

    run_arith(MULT, 32'd1000, 32'hFFFFFF00, 4, 1,
              32'hFFFFFF9C, 32'd7, 0);
    run_arith(DIV, 32'hFFFFFF9C, 32'd7, 2, 0, '0, '0, 1);

    run_arith(MULT, 32'h00010001, 32'h00020003, 0, 0, '0, '0, 0);
    run_arith(DIV, 32'h80000000, 32'hFFFFFFFF, T, 0, '0, '0, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) k = T + 1 + $urandom_range(0, 5);
      else if (r == 1) k = T;
      else k = $urandom_range(0, 6);
      if (o == MULT || (o == DIV && b != 32'd0))
        run_arith(o, a, b, k, 0, '0, '0, 1'($urandom_range(0, 1)));
      else
        run_simple(o, a, b);
    end

    run_arith(MULT, 32'd5, 32'd6, 1000, 0, '0, '0, 0);
    chk("timeout_set", 32'(timeout), 32'd1);
    run_arith(MULT, 32'd9, 32'd11, 3, 0, '0, '0, 0);
    chk("timeout_sticky", 32'(timeout), 32'd1);
    chk("after_to_lo", lo, 32'd99);

    op_valid = 1'b1;
    op = MULT;
    rs_val = 32'd123;
    rt_val = 32'd456;
    @(posedge clock);
    #1 op_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    unit_done = 1'b1;
    unit_hi = 32'hDEADBEEF;
    unit_lo = 32'hCAFEF00D;
    repeat (3) @(negedge clock);
    chk_zero("post_rst");
    unit_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have the following ports, in this order:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- op_valid  in  1  operation request
- op  in  3  3'b001 MULT, 3'b010 DIV, 3'b011 MTHI, 3'b100 MTLO; all others NOP
- rs_val  in  32  signed operand A / move source
- rt_val  in  32  signed operand B
- busy  out  1  operation in flight; request not accepted
- unit_start  out  1  one-cycle start pulse to the arithmetic unit
- unit_sel  out  1  0 = multiplier, 1 = divider
- unit_a  out  32  latched operand A
- unit_b  out  32  latched operand B
- unit_done  in  1  arithmetic unit result valid
- unit_hi  in  32  unit upper result (product high / remainder)
- unit_lo  in  32  unit lower result (product low / quotient)
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register
- div_zero  out  1  one-cycle pulse: DIV with rt_val = 0
- timeout  out  1  sticky: unit failed to respond
REQ-002 The block SHALL use the single parameter TIMEOUT_CYC, default 63, which sets the maximum number of wait cycles before abort.

Function
REQ-003 A request SHALL be accepted on a rising edge when op_valid = 1 and busy = 0; while busy = 1, op_valid SHALL be ignored and the requester holds the request.
REQ-004 State machine states SHALL be IDLE, START, WAIT.
REQ-005 IDLE, accepted MULT: latch unit_a = rs_val, unit_b = rt_val, unit_sel = 0; go to START; busy = 1 from the next cycle.
REQ-006 IDLE, accepted DIV with rt_val != 0: same as REQ-005 with unit_sel = 1.
REQ-007 IDLE, accepted DIV with rt_val = 0: no start is issued; div_zero = 1 for exactly the next cycle; HI/LO unchanged; stay IDLE.
REQ-008 IDLE, accepted MTHI/MTLO: hi (respectively lo) = rs_val on that edge; stay IDLE; busy stays 0.
REQ-009 IDLE, accepted NOP opcode: no state change.
REQ-010 START: unit_start = 1 for exactly this one cycle; clear wait counter; next state WAIT.
REQ-011 WAIT: wait counter increments by 1 every cycle.
REQ-012 WAIT, unit_done = 1: hi = unit_hi and lo = unit_lo on that edge; go to IDLE; busy = 0 from the next cycle.
REQ-013 WAIT, counter = TIMEOUT_CYC with unit_done = 0: set timeout = 1 (sticky until reset); HI/LO unchanged; go to IDLE.
REQ-014 If unit_done and the timeout count occur on the same edge, unit_done SHALL take priority: capture results; timeout unchanged.
REQ-015 unit_done SHALL be ignored in IDLE and START.
REQ-016 Operands and results SHALL pass through bit-exact; the block performs no arithmetic on data.
REQ-017 unit_a, unit_b and unit_sel SHALL hold stable from the accept edge until return to IDLE.
REQ-018 All outputs SHALL be registered; minimum MULT/DIV latency from accept to HI/LO update is 3 edges (accept, START, WAIT with unit_done = 1).

Reset
REQ-019 reset = 0 SHALL asynchronously force: state IDLE, busy = 0, unit_start = 0, unit_sel = 0, unit_a = 0, unit_b = 0, hi = 0, lo = 0, div_zero = 0, timeout = 0, counter = 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no HI/LO update; a unit_done arriving after reset release SHALL be ignored.

Verification
REQ-021 MULT rs = 0xFFFFFFFE, rt = 3; unit returns hi = 0xFFFFFFFF, lo = 0xFFFFFFFA two cycles after start -> exactly one unit_start pulse with unit_sel = 0; busy high 3 cycles; hi/lo captured.
REQ-022 DIV rs = 7, rt = 0 -> div_zero pulses once; no unit_start; hi/lo unchanged; busy stays 0.
REQ-023 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi = 0x12345678, lo = 0x9ABCDEF0; busy never asserted.
REQ-024 MULT with unit_done never asserted -> timeout = 1 after TIMEOUT_CYC wait cycles; return to IDLE; hi/lo unchanged; next MULT completes normally; timeout stays 1.
REQ-025 op_valid held with DIV during a busy MULT -> DIV accepted on the first cycle busy = 0; unit_sel = 1.
REQ-026 reset pulsed low during WAIT, then unit_done = 1 -> all outputs 0; no capture.
